// File: rtl/hub75_output_stage.sv
// HUB75 connector output stage: fixed-latency retiming of all panel signals plus
// anti-ghosting OE blanking around row changes and latch pulses.
// Optional blank-cycle statistics counter enabled by defining HUB75_BLANK_STATS_EN.
module hub75_output_stage #(
  parameter int DELAY      = 2,
  parameter int GUARD_PRE  = 2,
  parameter int GUARD_POST = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [2:0] rgb1_in,
  input  logic [2:0] rgb2_in,
  input  logic       clk_pixel_in,
  input  logic       row_latch_in,
  input  logic       output_enable_in,
  input  logic [3:0] row_address_in,
  input  logic       blank_req,
  output logic [2:0] rgb1_out,
  output logic [2:0] rgb2_out,
  output logic       clk_pixel_out,
  output logic       row_latch_out,
  output logic [3:0] row_address_out,
  output logic       oe_n_out,
  output logic       guard_active
`ifdef HUB75_BLANK_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [15:0] blank_cycles
`endif
);

  localparam int PW = 13;
  localparam int CW = $clog2(DELAY + GUARD_POST + 1);
  // Delay stage at which an event starts blanking: GUARD_PRE cycles before the pins.
  localparam int ES = DELAY - GUARD_PRE;
  localparam logic [CW-1:0] LOAD = CW'(GUARD_PRE + GUARD_POST - 1);

  // Stage word layout: {rgb1[12:10], rgb2[9:7], clk_pixel[6], latch[5], row[4:1], oe[0]}
  logic [PW-1:0] r_pipe [0:DELAY];
  logic          r_evt  [0:ES];
  logic [CW-1:0] r_cnt;
  logic          r_blank_q;

  logic          w_evt;
  logic          w_load;
  logic          w_guard;
  logic          w_oe_dly;
  logic [CW-1:0] w_cnt_dec;
  logic [CW-1:0] w_cnt_next;

  // Stage 0 holds the previous sample, so it doubles as the edge-detect history.
  assign w_evt = (row_address_in != r_pipe[0][4:1]) | (row_latch_in & ~r_pipe[0][5]);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= DELAY; i++) r_pipe[i] <= '0;
      for (int i = 0; i <= ES; i++) r_evt[i] <= 1'b0;
      r_cnt     <= '0;
      r_blank_q <= 1'b0;
    end else begin
      r_pipe[0] <= {rgb1_in, rgb2_in, clk_pixel_in, row_latch_in, row_address_in,
                    output_enable_in};
      for (int i = 1; i <= DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      r_evt[0] <= w_evt;
      for (int i = 1; i <= ES; i++) r_evt[i] <= r_evt[i-1];
      r_cnt     <= w_cnt_next;
      r_blank_q <= blank_req;
    end
  end

  // The load cycle itself is blanked by w_load; the counter covers the remainder.
  assign w_load  = r_evt[ES];
  assign w_guard = w_load | (r_cnt != '0);

  always_comb begin
    w_cnt_dec  = (r_cnt != '0) ? (r_cnt - CW'(1)) : '0;
    w_cnt_next = w_cnt_dec;
    if (w_load && (LOAD > w_cnt_dec)) w_cnt_next = LOAD;
  end

  assign w_oe_dly        = r_pipe[DELAY][0];
  assign rgb1_out        = r_pipe[DELAY][12:10];
  assign rgb2_out        = r_pipe[DELAY][9:7];
  assign clk_pixel_out   = r_pipe[DELAY][6];
  assign row_latch_out   = r_pipe[DELAY][5];
  assign row_address_out = r_pipe[DELAY][4:1];
  assign oe_n_out        = ~(w_oe_dly & ~w_guard & ~r_blank_q);
  assign guard_active    = w_oe_dly & w_guard;

`ifdef HUB75_BLANK_STATS_EN
  logic [15:0] r_blank_cycles;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_blank_cycles <= '0;
    end else if (stats_clear) begin
      r_blank_cycles <= '0;
    end else if (guard_active && (r_blank_cycles != 16'hFFFF)) begin
      r_blank_cycles <= r_blank_cycles + 16'd1;
    end
  end

  assign blank_cycles = r_blank_cycles;
`endif

endmodule

// File: tb/tb_hub75_output_stage.sv
// Bench for hub75_output_stage: scenario table with a data scoreboard and an
// event-window OE model, directed pin-timing checks and a mid-run reset sequence.
module tb_hub75_output_stage;
  localparam int DELAY = 2;
  localparam int GP    = 2;
  localparam int GPOST = 3;
  localparam int L     = DELAY + 1;
  localparam int N     = 56;
  localparam int DW    = 12;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [2:0] rgb1_in = '0, rgb2_in = '0;
  logic       clk_pixel_in = 1'b0, row_latch_in = 1'b0, output_enable_in = 1'b0;
  logic [3:0] row_address_in = '0;
  logic       blank_req = 1'b0;
  logic [2:0] rgb1_out, rgb2_out;
  logic       clk_pixel_out, row_latch_out, oe_n_out, guard_active;
  logic [3:0] row_address_out;
`ifdef HUB75_BLANK_STATS_EN
  logic        stats_clear = 1'b0;
  logic [15:0] blank_cycles;
`endif

  always #5 clk_in = ~clk_in;

  hub75_output_stage #(.DELAY(DELAY), .GUARD_PRE(GP), .GUARD_POST(GPOST)) dut (
    .clk_in(clk_in), .reset(reset),
    .rgb1_in(rgb1_in), .rgb2_in(rgb2_in), .clk_pixel_in(clk_pixel_in),
    .row_latch_in(row_latch_in), .output_enable_in(output_enable_in),
    .row_address_in(row_address_in), .blank_req(blank_req),
    .rgb1_out(rgb1_out), .rgb2_out(rgb2_out), .clk_pixel_out(clk_pixel_out),
    .row_latch_out(row_latch_out), .row_address_out(row_address_out),
    .oe_n_out(oe_n_out), .guard_active(guard_active)
`ifdef HUB75_BLANK_STATS_EN
    , .stats_clear(stats_clear), .blank_cycles(blank_cycles)
`endif
  );

  typedef struct {
    logic [2:0] rgb1;
    logic [2:0] rgb2;
    logic       clk_pixel;
    logic       latch;
    logic       oe;
    logic       blank;
    logic [3:0] row;
  } vec_t;

  vec_t            vecs [N];
  logic [DW-1:0]   exp_q[$];
  logic            h_oe [N], h_blank [N], h_evt [N], h_latch [N];
  logic [3:0]      h_row [N];
  logic            act_oe_n [N], act_ga [N], act_latch [N];
  logic [3:0]      act_row [N];
  int              checks = 0;
  int              passes = 0;
  int              model_ga_sum = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // OE suppressed in cycle c if any event k has c within [k+L-GP, k+L+GPOST-1].
  function automatic logic model_guard(input int c);
    for (int k = c - L - GPOST + 1; k <= c - L + GP; k++)
      if (k >= 0 && k < c && h_evt[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [DW-1:0] got, e;
    logic          g, oe_d, bl, e_oe_n, e_ga;
    logic [3:0]    prev_row;
    logic          prev_latch;

    for (int c = 0; c < N; c++) begin
      vecs[c].rgb1      = 3'($urandom_range(0, 7));
      vecs[c].rgb2      = 3'($urandom_range(0, 7));
      vecs[c].clk_pixel = 1'(c % 2);
      vecs[c].latch     = (c == 20 || c == 32);
      vecs[c].oe        = 1'b1;
      vecs[c].blank     = (c >= 40 && c <= 43);
      vecs[c].row       = (c < 10) ? 4'd5 : (c < 30) ? 4'd6 : 4'd7;
    end

    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    for (int i = 0; i < L; i++) exp_q.push_back('0);

    for (int c = 0; c < N; c++) begin
      got = {rgb1_out, rgb2_out, clk_pixel_out, row_latch_out, row_address_out};
      e = exp_q.pop_front();
      check($sformatf("data c%0d", c), 32'(got), 32'(e));
      g      = model_guard(c);
      oe_d   = (c >= L) ? h_oe[c-L] : 1'b0;
      bl     = (c >= 1) ? h_blank[c-1] : 1'b0;
      e_oe_n = ~(oe_d & ~g & ~bl);
      e_ga   = oe_d & g;
      if (e_ga) model_ga_sum++;
      check($sformatf("oe_n c%0d", c), 32'(oe_n_out), 32'(e_oe_n));
      check($sformatf("guard_active c%0d", c), 32'(guard_active), 32'(e_ga));
      act_oe_n[c] = oe_n_out; act_ga[c] = guard_active;
      act_row[c] = row_address_out; act_latch[c] = row_latch_out;

      rgb1_in = vecs[c].rgb1; rgb2_in = vecs[c].rgb2;
      clk_pixel_in = vecs[c].clk_pixel; row_latch_in = vecs[c].latch;
      output_enable_in = vecs[c].oe; blank_req = vecs[c].blank;
      row_address_in = vecs[c].row;
      prev_row   = (c > 0) ? h_row[c-1] : 4'd0;
      prev_latch = (c > 0) ? h_latch[c-1] : 1'b0;
      h_row[c] = vecs[c].row; h_latch[c] = vecs[c].latch;
      h_oe[c] = vecs[c].oe; h_blank[c] = vecs[c].blank;
      h_evt[c] = (vecs[c].row != prev_row) || (vecs[c].latch && !prev_latch);
      exp_q.push_back({vecs[c].rgb1, vecs[c].rgb2, vecs[c].clk_pixel, vecs[c].latch,
                       vecs[c].row});
      next_cycle();
    end

`ifdef HUB75_BLANK_STATS_EN
    check("blank_cycles total", 32'(blank_cycles), 32'(model_ga_sum));
`endif

    // Directed pin timing for the row change, latch, overlap and blank_req scenarios.
    for (int c = 10; c <= 16; c++) begin
      check($sformatf("row oe_n c%0d", c), 32'(act_oe_n[c]), 32'(c >= 11 && c <= 15));
      check($sformatf("row ga c%0d", c), 32'(act_ga[c]), 32'(c >= 11 && c <= 15));
    end
    check("row_out c12", 32'(act_row[12]), 32'd5);
    check("row_out c13", 32'(act_row[13]), 32'd6);
    for (int c = 20; c <= 26; c++) begin
      check($sformatf("latch oe_n c%0d", c), 32'(act_oe_n[c]), 32'(c >= 21 && c <= 25));
      check($sformatf("latch_out c%0d", c), 32'(act_latch[c]), 32'(c == 23));
    end
    for (int c = 30; c <= 38; c++)
      check($sformatf("overlap oe_n c%0d", c), 32'(act_oe_n[c]), 32'(c >= 31 && c <= 37));
    for (int c = 40; c <= 45; c++) begin
      check($sformatf("blank oe_n c%0d", c), 32'(act_oe_n[c]), 32'(c >= 41 && c <= 44));
      check($sformatf("blank ga c%0d", c), 32'(act_ga[c]), 32'd0);
    end

    // Mid-run reset with every input high: instant dark, no stale data afterwards.
    rgb1_in = 3'b111; rgb2_in = 3'b111; clk_pixel_in = 1'b1; row_latch_in = 1'b1;
    output_enable_in = 1'b1; row_address_in = 4'hF; blank_req = 1'b1;
    repeat (3) next_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("rst oe_n", 32'(oe_n_out), 32'd1);
    check("rst data", 32'({rgb1_out, rgb2_out, clk_pixel_out, row_latch_out, row_address_out}),
          32'd0);
    check("rst guard_active", 32'(guard_active), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    check("refill rgb1 c1", 32'(rgb1_out), 32'd0);
    next_cycle();
    check("refill rgb1 c2", 32'(rgb1_out), 32'd0);
    check("refill row c2", 32'(row_address_out), 32'd0);
    next_cycle();
    check("refill rgb1 c3", 32'(rgb1_out), 32'd7);
    check("refill row c3", 32'(row_address_out), 32'hF);

`ifdef HUB75_BLANK_STATS_EN
    blank_req = 1'b0; row_latch_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      row_address_in = 4'(i);
      next_cycle();
    end
    check("stats guard before clear", 32'(guard_active), 32'd1);
    stats_clear = 1'b1;
    row_address_in = 4'd9;
    next_cycle();
    stats_clear = 1'b0;
    check("stats clear wins", 32'(blank_cycles), 32'd0);
    for (int i = 0; i < 70000; i++) begin
      row_address_in = 4'(i);
      next_cycle();
    end
    check("stats saturate", 32'(blank_cycles), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hub75_output_stage.md
Name: hub75_output_stage

Overview:
- Final registered stage between the matrix scan/pixel-split logic and the HUB75 connector pins, in the clk_root domain.
- Retimes RGB, pixel clock, latch, row address and OE through a fixed-latency delay line so every pin switches from a flop, with no skew.
- Enforces anti-ghosting blanking: OE is forced inactive for a guard window around every row-address change and every row-latch pulse.
- Emits active-low OE for the connector.

Parameters:
- DELAY, 2, extra delay-line stages after the input register; total latency L = DELAY+1; legal 1..7.
- GUARD_PRE, 2, output cycles blanked before an event reaches the pins; must be <= DELAY.
- GUARD_POST, 3, output cycles blanked after an event reaches the pins (event cycle included); legal 1..15.

Ports:
- clk_in  input  1  clk_root; all logic on its rising edge.
- reset  input  1  asynchronous, active-high.
- rgb1_in  input  3  top-half R,G,B.
- rgb2_in  input  3  bottom-half R,G,B.
- clk_pixel_in  input  1  pixel shift clock from scan logic.
- row_latch_in  input  1  row latch.
- output_enable_in  input  1  active-high OE request from scan logic.
- row_address_in  input  4  active row A..D.
- blank_req  input  1  force blank, e.g. during panel init.
- rgb1_out  output  3  retimed rgb1.
- rgb2_out  output  3  retimed rgb2.
- clk_pixel_out  output  1  retimed pixel clock.
- row_latch_out  output  1  retimed latch.
- row_address_out  output  4  retimed row address.
- oe_n_out  output  1  active-low OE to pins.
- guard_active  output  1  high in any cycle where the guard suppresses a requested OE.

Behaviour:
- Reset (async assert): all delay-line stages clear to 0; guard counter clears to 0. Outputs: rgb*/clk_pixel/latch/row_address_out = 0; oe_n_out = 1 (panel dark); guard_active = 0.
- Datapath: each non-OE input appears at its output exactly L cycles after it is sampled, unmodified.
- Event definition: event at input sample k when row_address_in(k) != row_address_in(k-1), or row_latch_in(k)=1 and row_latch_in(k-1)=0. The first sample after reset compares against 0.
- Guard window: sample k reaches the pins at output cycle k+L. For an event at sample k, OE is suppressed for output cycles k+L-GUARD_PRE through k+L+GUARD_POST-1.
- Overlapping events: windows OR together; a new event extends the window and never shortens it.
- oe_n_out = ~(oe_delayed & ~guard & ~blank_q); oe_delayed is output_enable_in delayed by L.
- blank_req: registered once (blank_q); takes effect on oe_n_out 1 cycle after assertion, independent of L. Release lets OE follow oe_delayed next cycle, subject to guard.
- guard_active = oe_delayed & guard (not blank-related).
- Implementation: a down-counter loaded with GUARD_PRE+GUARD_POST when the event is at delay stage GUARD_PRE before the output. Load saturates to the max of the current and new value.
- Counter width: ceil(log2(DELAY+GUARD_POST+1)).
- Reset mid-operation: instant dark; no stale data emerges after release. Outputs remain 0 for L cycles while the line refills.
- No combinational path from any input to any output.

Optional Feature:
- Macro HUB75_BLANK_STATS_EN.
- Defined: adds output blank_cycles (16 bits). It counts cycles where guard_active=1, saturates at 16'hFFFF, and clears on reset or on a 1-cycle pulse of added input stats_clear. Clear wins over increment in the same cycle.
- Undefined: neither port exists; no counter logic is synthesized.

Test Plan:
- Reset: assert reset with all inputs=1 -> same cycle oe_n_out=1 and all other outputs 0. Release with inputs held -> rgb1_out=3'b111 exactly 3 cycles later (DELAY=2).
- Row change: OE held 1; row_address_in 4'd5->4'd6 at sample 10 -> row_address_out changes at cycle 13. oe_n_out=1 for cycles 11..15, =0 at 10 and 16. guard_active=1 on 11..15.
- Latch pulse: single-cycle row_latch_in at sample 20, row constant -> row_latch_out high at cycle 23 only. oe_n_out high 21..25.
- Overlap: row change at 30, latch at 32 -> a single contiguous blank, cycles 31..37.
- blank_req: pulse blank_req for 4 cycles starting cycle 40, OE=1, no events -> oe_n_out=1 on cycles 41..44; guard_active stays 0.
- Stats (HUB75_BLANK_STATS_EN): run the row-change scenario -> blank_cycles=5. Hold stats_clear and an event together -> stats_clear wins and reads 0 the next cycle. Force 70000 guarded cycles -> saturates at 65535.
